// File: rtl/lcd_content_ctrl.sv
// Owns the four LCD digit registers: arbitrates two requesters, converts hex to segments
// one nibble per clock into a shadow buffer, then commits atomically. Optional blink: LCD_CONTENT_CTRL_BLINK_EN.
module lcd_content_ctrl #(
    parameter int CLOCK_HZ = 1_000_000,
    parameter int BLINK_MS = 500
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req0_i,
    input  logic [15:0] Value0_i,
    input  logic [3:0]  Dp0_i,
    input  logic        Lzb0_i,
    output logic        Ack0_o,
    input  logic        Req1_i,
    input  logic [15:0] Value1_i,
    input  logic [3:0]  Dp1_i,
    input  logic        Lzb1_i,
    output logic        Ack1_o,
    input  logic        Blink_i,
    output logic [7:0]  Digit3_o,
    output logic [7:0]  Digit2_o,
    output logic [7:0]  Digit1_o,
    output logic [7:0]  Digit0_o,
    output logic        Busy_o,
    output logic        Updated_o,
    output logic [1:0]  State_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_t;

    state_t      state;
    logic [15:0] value_q;
    logic [3:0]  dp_q;
    logic        lzb_q;
    logic [1:0]  idx;
    logic        zero_run;
    logic        last_grant;
    logic [7:0]  shadow [4];
    logic [7:0]  disp [4];

    logic        grant1;
    logic [3:0]  nib;
    logic        blank;
    logic [7:0]  seg;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    endfunction

    // Under contention the requester not granted last wins; a lone request wins outright.
    always_comb begin
        grant1 = Req1_i && (!Req0_i || !last_grant);
        nib    = value_q[{idx, 2'b00} +: 4];
        blank  = lzb_q && zero_run && (nib == 4'h0) && (idx != 2'd0);
        seg    = {dp_q[idx], blank ? 7'h00 : font(nib)};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            value_q    <= '0;
            dp_q       <= '0;
            lzb_q      <= 1'b0;
            idx        <= 2'd3;
            zero_run   <= 1'b1;
            last_grant <= 1'b1;
            Ack0_o     <= 1'b0;
            Ack1_o     <= 1'b0;
            Busy_o     <= 1'b0;
            Updated_o  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            Ack0_o    <= 1'b0;
            Ack1_o    <= 1'b0;
            Updated_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req0_i || Req1_i) begin
                        Ack0_o     <= !grant1;
                        Ack1_o     <= grant1;
                        last_grant <= grant1;
                        value_q    <= grant1 ? Value1_i : Value0_i;
                        dp_q       <= grant1 ? Dp1_i : Dp0_i;
                        lzb_q      <= grant1 ? Lzb1_i : Lzb0_i;
                        idx        <= 2'd3;
                        zero_run   <= 1'b1;
                        Busy_o     <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    // zero_run tracks whether every digit converted so far was zero
                    shadow[idx] <= seg;
                    zero_run    <= zero_run && (nib == 4'h0);
                    idx         <= idx - 2'd1;
                    if (idx == 2'd0) state <= COMMIT;
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++) disp[i] <= shadow[i];
                    Updated_o <= 1'b1;
                    Busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign State_o = state;

`ifdef LCD_CONTENT_CTRL_BLINK_EN
    localparam longint HALF_RAW = longint'(CLOCK_HZ) * longint'(BLINK_MS) / 1000;
    localparam int     HALF     = (HALF_RAW < 1) ? 1 : int'(HALF_RAW);
    localparam int     CW       = (HALF < 2) ? 1 : $clog2(HALF);

    logic [CW-1:0] blink_cnt;
    logic          phase_on;
    logic [7:0]    out_q [4];

    // Output register sees the commit directly so blinking adds no commit latency.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            if (blink_cnt == CW'(HALF - 1)) begin
                blink_cnt <= '0;
                phase_on  <= !phase_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            for (int i = 0; i < 4; i++)
                out_q[i] <= (Blink_i && !phase_on) ? 8'h00 : ((state == COMMIT) ? shadow[i] : disp[i]);
        end
    end

    assign Digit3_o = out_q[3];
    assign Digit2_o = out_q[2];
    assign Digit1_o = out_q[1];
    assign Digit0_o = out_q[0];
`else
    logic unused_blink;
    assign unused_blink = Blink_i;
    localparam int unused_cfg = CLOCK_HZ + BLINK_MS;

    assign Digit3_o = disp[3];
    assign Digit2_o = disp[2];
    assign Digit1_o = disp[1];
    assign Digit0_o = disp[0];
`endif

endmodule

// File: tb/tb_lcd_content_ctrl.sv
// Bench for lcd_content_ctrl: vector table, hand sequences for arbitration and abort,
// randomized updates against a nibble-level reference model.
module tb_lcd_content_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0_i = 1'b0, Req1_i = 1'b0;
    logic [15:0] Value0_i = '0, Value1_i = '0;
    logic [3:0]  Dp0_i = '0, Dp1_i = '0;
    logic        Lzb0_i = 1'b0, Lzb1_i = 1'b0;
    logic        Blink_i = 1'b0;
    logic        Ack0_o, Ack1_o, Busy_o, Updated_o;
    logic [7:0]  Digit3_o, Digit2_o, Digit1_o, Digit0_o;
    logic [1:0]  State_o;
    logic [31:0] digits;

    int checks = 0;
    int errors = 0;
    int rr_next = 0;

    localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    typedef struct {
        int          who;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    lcd_content_ctrl #(.CLOCK_HZ(1000), .BLINK_MS(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0_i(Req0_i), .Value0_i(Value0_i), .Dp0_i(Dp0_i), .Lzb0_i(Lzb0_i), .Ack0_o(Ack0_o),
        .Req1_i(Req1_i), .Value1_i(Value1_i), .Dp1_i(Dp1_i), .Lzb1_i(Lzb1_i), .Ack1_o(Ack1_o),
        .Blink_i(Blink_i),
        .Digit3_o(Digit3_o), .Digit2_o(Digit2_o), .Digit1_o(Digit1_o), .Digit0_o(Digit0_o),
        .Busy_o(Busy_o), .Updated_o(Updated_o), .State_o(State_o)
    );

    assign digits = {Digit3_o, Digit2_o, Digit1_o, Digit0_o};

    always #5 Clock = ~Clock;

    // Reference: a digit is blank when it and everything above it is zero.
    function automatic logic [31:0] model(input logic [15:0] v, input logic [3:0] dp, input logic lzb);
        logic [31:0] r;
        logic [3:0]  n;
        logic        b;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            n = v[4*d +: 4];
            b = lzb && (d > 0) && ((v >> (4*d)) == 16'h0);
            r[8*d +: 8] = {dp[d], b ? 7'h00 : FONT[n][6:0]};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with the controller idle.
    task automatic start_and_check(input bit r0, input bit r1, input int exp_who,
                                   input logic [31:0] exp, input string name);
        int  busy_cnt;
        bit  seen;
        Req0_i = r0;
        Req1_i = r1;
        @(posedge Clock); #1;
        check({name, " ack0"}, 32'(Ack0_o), 32'(exp_who == 0));
        check({name, " ack1"}, 32'(Ack1_o), 32'(exp_who == 1));
        Req0_i = 1'b0;
        Req1_i = 1'b0;
        busy_cnt = Busy_o ? 1 : 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clock); #1;
            if (Updated_o) begin
                seen = 1'b1;
                break;
            end
            if (Busy_o) busy_cnt++;
        end
        check({name, " updated seen"}, 32'(seen), 32'd1);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd5);
        check({name, " digits"}, digits, exp);
        @(posedge Clock); #1;
        check({name, " updated one cycle"}, 32'(Updated_o), 32'd0);
        rr_next = 1 - exp_who;
    endtask

    task automatic load(input int who, input logic [15:0] v, input logic [3:0] dp, input logic lzb);
        if (who == 0) begin
            Value0_i = v; Dp0_i = dp; Lzb0_i = lzb;
        end else begin
            Value1_i = v; Dp1_i = dp; Lzb1_i = lzb;
        end
    endtask

    initial begin
        logic [15:0] v0, v1;
        logic [3:0]  d0, d1;
        logic        l0, l1;
        int          mode, who, upd_cnt;

        vecs[0] = '{0, 16'h12AF, 4'b0000, 1'b0, 32'h065B7771};
        vecs[1] = '{1, 16'h0070, 4'b0100, 1'b1, 32'h0080073F};
        vecs[2] = '{1, 16'h0000, 4'b0000, 1'b1, 32'h0000003F};
        vecs[3] = '{0, 16'hFFFF, 4'b1111, 1'b1, 32'hF1F1F1F1};
        vecs[4] = '{1, 16'h0001, 4'b1000, 1'b1, 32'h80000006};
        vecs[5] = '{0, 16'h1000, 4'b0000, 1'b1, 32'h063F3F3F};
        vecs[6] = '{1, 16'hBC9D, 4'b0000, 1'b0, 32'h7C396F5E};

        // Reset held 3 cycles
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("reset digits", digits, 32'h0);
        check("reset ack0", 32'(Ack0_o), 32'd0);
        check("reset ack1", 32'(Ack1_o), 32'd0);
        check("reset busy", 32'(Busy_o), 32'd0);
        check("reset updated", 32'(Updated_o), 32'd0);
        @(posedge Clock); #1;

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].who, vecs[i].value, vecs[i].dp, vecs[i].lzb);
            start_and_check(vecs[i].who == 0, vecs[i].who == 1, vecs[i].who, vecs[i].exp,
                            $sformatf("vec%0d", i));
        end

        // Both requesters held after reset: 0, 1, 0 at E0, E6, E12
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        rr_next = 0;
        load(0, 16'h1111, 4'h0, 1'b0);
        load(1, 16'h2222, 4'h0, 1'b0);
        Req0_i = 1'b1;
        Req1_i = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(posedge Clock); #1;
            check($sformatf("rr ack0 k%0d", k), 32'(Ack0_o), 32'(k == 0 || k == 12));
            check($sformatf("rr ack1 k%0d", k), 32'(Ack1_o), 32'(k == 6));
            if (k == 0) Value0_i = 16'h3333;
            if (k == 12) begin
                Req0_i = 1'b0;
                Req1_i = 1'b0;
            end
            if (k == 5)  check("rr first value", digits, model(16'h1111, 4'h0, 1'b0));
            if (k == 11) check("rr second value", digits, model(16'h2222, 4'h0, 1'b0));
            if (k == 17) check("rr third value", digits, model(16'h3333, 4'h0, 1'b0));
        end
        rr_next = 1;

        // Abort: reset at E2 of an update
        load(0, 16'h1234, 4'h0, 1'b0);
        start_and_check(1'b1, 1'b0, 0, 32'h065B4F66, "pre abort");
        load(0, 16'h8888, 4'h0, 1'b0);
        load(1, 16'h5555, 4'h0, 1'b0);
        Req0_i = 1'b1;
        @(posedge Clock); #1;
        Req0_i = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        rr_next = 0;
        check("abort digits", digits, 32'h0);
        check("abort busy", 32'(Busy_o), 32'd0);
        upd_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            if (Updated_o) upd_cnt++;
        end
        check("abort no updated", 32'(upd_cnt), 32'd0);
        start_and_check(1'b1, 1'b1, 0, 32'h7F7F7F7F, "post abort");

        // Randomized updates against the model
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 2);
            v0 = 16'($urandom); v1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v0 = v0 & 16'h00FF;
            if ($urandom_range(0, 3) == 0) v1 = v1 & 16'h000F;
            d0 = 4'($urandom); d1 = 4'($urandom);
            l0 = 1'($urandom); l1 = 1'($urandom);
            load(0, v0, d0, l0);
            load(1, v1, d1, l1);
            who = (mode < 2) ? mode : rr_next;
            start_and_check(mode != 1, mode != 0, who,
                            (who == 0) ? model(v0, d0, l0) : model(v1, d1, l1),
                            $sformatf("rand%0d", i));
        end

`ifdef LCD_CONTENT_CTRL_BLINK_EN
        begin
            logic [31:0] s [12];
            int t;
            load(0, 16'h1234, 4'h0, 1'b0);
            start_and_check(1'b1, 1'b0, 0, 32'h065B4F66, "blink setup");
            Blink_i = 1'b1;
            @(posedge Clock); #1;
            @(posedge Clock); #1;
            for (int k = 0; k < 12; k++) begin
                @(posedge Clock); #1;
                s[k] = digits;
            end
            t = (s[1] != s[0]) ? 1 : 2;
            for (int k = 0; k < 12; k++) begin
                if (k >= t)
                    check($sformatf("blink k%0d", k), s[k],
                          (((k - t) / 2) % 2 == 0) ? s[t] : ((s[t] == 32'h0) ? 32'h065B4F66 : 32'h0));
                else
                    check($sformatf("blink pre k%0d", k), 32'(s[k] == 32'h0 || s[k] == 32'h065B4F66), 32'd1);
            end
            Blink_i = 1'b0;
            @(posedge Clock); #1;
            for (int k = 0; k < 6; k++) begin
                @(posedge Clock); #1;
                check($sformatf("steady k%0d", k), digits, 32'h065B4F66);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_content_ctrl.md
Name: lcd_content_ctrl

Overview:
- Controller that owns the four digit registers feeding the 4-COM/8-SEG multiplexed LCD driver (Digit3..Digit0 segment inputs).
- Two independent requesters share the display through a round-robin arbiter.
- A granted request carries a 16-bit hex value, a decimal-point mask and a leading-zero-blank flag. These are converted one nibble per clock into a shadow buffer, then committed to the driver atomically so the driver never shows a partial update.

Parameters:
- CLOCK_HZ, 1_000_000, system clock frequency in Hz; used only for blink timing.
- BLINK_MS, 500, blink half-period in ms. Half-period in cycles = CLOCK_HZ*BLINK_MS/1000, minimum 1. Used only with the optional feature.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req0_i  input  1  requester 0 request, level.
- Value0_i  input  16  requester 0 hex value; [15:12] goes to Digit3, [3:0] to Digit0.
- Dp0_i  input  4  requester 0 decimal points; bit n lights DP of Digit n.
- Lzb0_i  input  1  requester 0 leading-zero blanking enable.
- Ack0_o  output  1  one-cycle grant/latch pulse to requester 0.
- Req1_i, Value1_i, Dp1_i, Lzb1_i, Ack1_o: same as requester 0, for requester 1.
- Blink_i  input  1  blink request; ignored unless the optional feature is compiled in.
- Digit3_o..Digit0_o  output  8 each  segment patterns to the LCD driver; bit0..6 = A..G, bit7 = DP, 1 = lit.
- Busy_o  output  1  high when not IDLE.
- Updated_o  output  1  one-cycle pulse on commit.

Behaviour:
- Reset (synchronous, Reset=1 at an edge):
  - State IDLE; Digit outputs 8'h00; Ack0/1, Updated, Busy all 0.
  - Shadow buffer 0; round-robin pointer favours requester 0; blink counter 0.
- FSM states are IDLE, CONVERT, COMMIT.
- IDLE, edge E0 with any Req high:
  - Arbitrate: a single requester wins outright. If both request, the winner is the one not granted last.
  - Latch that requester's Value/Dp/Lzb; the pointer records the winner.
  - Ack of the winner is 1 for exactly the cycle after E0.
  - Next state CONVERT with digit index 3.
- CONVERT, edges E1..E4:
  - One nibble per edge, order Digit3, 2, 1, 0.
  - Font table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Leading-zero blanking (latched Lzb=1): a digit among 3..1 gets segments A..G = 0 while all higher digits are also zero. Digit0 is never blanked.
  - DP bit = latched Dp[n], applied even on blanked digits.
  - After E4, state COMMIT.
- COMMIT, edge E5:
  - All four Digit outputs load from the shadow buffer simultaneously.
  - Updated_o is 1 for the following cycle; state returns to IDLE.
- Latency: request sampled at E0, new digits visible after E5. Earliest next grant is at E6.
- Busy_o = 1 from after E0 through the cycle ending at E5.
- Requests are level-sensitive:
  - A Req still high when IDLE is re-entered is a new request; requesters drop Req on seeing Ack.
  - Value/Dp/Lzb are sampled only at E0; later changes have no effect on the update in flight.
- Reset mid-CONVERT/COMMIT: the update is abandoned. Outputs go blank, no Updated pulse, pointer returns to favour requester 0.
- Digit outputs hold their last committed value indefinitely between updates.

Optional Feature:
- Macro LCD_CONTENT_CTRL_BLINK_EN.
- With it defined:
  - A free-running counter toggles a phase bit every half-period. Phase resets to "on".
  - While Blink_i=1 and phase is "off", all Digit outputs read 8'h00. The committed contents are unaffected and reappear in the "on" phase.
  - The masking is registered: it takes effect one edge after the phase/Blink_i change.
- Without it: no counter is built, Blink_i is unused, and Digit outputs always equal the committed contents.

Test Plan:
- Reset held 3 cycles, then released idle -> Digit3..0 = 00 00 00 00; Ack0/1, Busy, Updated = 0.
- Req0 with Value0=16'h12AF, Dp0=0, Lzb0=0 -> Ack0 pulse for 1 cycle after E0; after E5 Digits = 06 5B 77 71; Updated pulse once; Busy high for 5 cycles.
- Req1 with Value1=16'h0070, Dp1=4'b0100, Lzb1=1 -> Digits = 00 80 07 3F. Then 16'h0000, Lzb1=1 -> 00 00 00 3F.
- Req0 and Req1 held high together after reset -> grant order Ack0, Ack1, Ack0 (at E0, E6, E12) with each requester's value committed in turn. A mid-update Value change is not displayed.
- Reset asserted at E2 of an update to 16'h8888 after prior display 16'h1234 -> Digits 00 00 00 00 and no Updated pulse. A following Req0 of 16'h8888 displays 7F 7F 7F 7F.
- With LCD_CONTENT_CTRL_BLINK_EN, CLOCK_HZ=1000, BLINK_MS=2, display 16'h1234, Blink_i=1 -> Digits alternate 06 5B 4F 66 / 00 00 00 00 every 2 cycles. Blink_i=0 -> steady 06 5B 4F 66.
